// File: rtl/audio_pkg.sv
// Shared audio definitions: note half-period constants for the default 100 MHz
// clock, the rest encoding and the melody sequencer state enum.
package audio_pkg;

    localparam int unsigned DEF_CLK_HZ = 100_000_000;

    // Half-period in clk cycles = CLK_HZ / (2 * f), with f rounded to whole Hz.
    localparam int unsigned HP_B4  = DEF_CLK_HZ / (2 * 494);
    localparam int unsigned HP_C5  = DEF_CLK_HZ / (2 * 523);
    localparam int unsigned HP_DS5 = DEF_CLK_HZ / (2 * 622);
    localparam int unsigned HP_E5  = DEF_CLK_HZ / (2 * 659);
    localparam int unsigned HP_F5  = DEF_CLK_HZ / (2 * 698);
    localparam int unsigned HP_FS5 = DEF_CLK_HZ / (2 * 740);
    localparam int unsigned HP_G5  = DEF_CLK_HZ / (2 * 784);
    localparam int unsigned HP_GS5 = DEF_CLK_HZ / (2 * 831);
    localparam int unsigned HP_A5  = DEF_CLK_HZ / (2 * 880);
    localparam int unsigned HP_B5  = DEF_CLK_HZ / (2 * 988);
    localparam int unsigned HP_C6  = DEF_CLK_HZ / (2 * 1047);
    localparam int unsigned HP_E6  = DEF_CLK_HZ / (2 * 1319);
    localparam int unsigned HP_G6  = DEF_CLK_HZ / (2 * 1568);
    localparam int unsigned REST   = 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_PLAY,
        S_GAP,
        S_NEXT
    } state_e;

endpackage

// File: rtl/tone_gen.sv
// Square-wave generator: toggles every half_period cycles, silent on rest,
// phase-held (but muted) while frozen, and zero-phase after restart.
module tone_gen #(
    parameter int HP_W = 22
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            restart,
    input  logic            freeze,
    input  logic [HP_W-1:0] half_period,
    output logic            sound
);

    logic [HP_W-1:0] cnt_q, cnt_d;
    logic            tone_q, tone_d;
    logic            sound_q, sound_d;

    always_comb begin
        cnt_d  = cnt_q;
        tone_d = tone_q;
        if (restart || half_period == '0) begin
            cnt_d  = '0;
            tone_d = 1'b0;
        end else if (!freeze) begin
            if (cnt_q == half_period - 1'b1) begin
                cnt_d  = '0;
                tone_d = ~tone_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        // Phase lives in tone_q; the pin is muted separately so pause keeps phase.
        sound_d = tone_d & ~freeze;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            tone_q  <= 1'b0;
            sound_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            tone_q  <= tone_d;
            sound_q <= sound_d;
        end
    end

    assign sound = sound_q;

endmodule

// File: rtl/melody_player.sv
// Tune sequencer: walks an external synchronous note ROM, times each note in
// tempo ticks, inserts optional gaps, and drives a registered square wave.
module melody_player
    import audio_pkg::*;
#(
    parameter int CLK_HZ    = 100_000_000,
    parameter int TICK_HZ   = 32,
    parameter int ADDR_W    = 6,
    parameter int HP_W      = 22,
    parameter int DUR_W     = 4,
    parameter int GAP_TICKS = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              play,
    input  logic              stop,
    input  logic              pause,
    input  logic              loop_en,
    output logic [ADDR_W-1:0] note_addr,
    input  logic [HP_W-1:0]   rom_half_period,
    input  logic [DUR_W-1:0]  rom_dur,
    input  logic              rom_last,
    output logic              sound,
    output logic              busy,
    output logic              done
);

    localparam int DIV    = CLK_HZ / TICK_HZ;
    localparam int TICK_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int GAP_W  = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(DIV - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   note_addr_q, note_addr_d;
    logic [HP_W-1:0]     hp_q, hp_d;
    logic [DUR_W-1:0]    dur_q, dur_d;
    logic                last_q, last_d;
    logic [TICK_W-1:0]   tick_q, tick_d;
    logic [DUR_W-1:0]    beat_q, beat_d;
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic                done_q, done_d;
    logic                tick;
    logic [DUR_W-1:0]    dur_end;
    logic                restart;

    assign tick    = (tick_q == TICK_LAST);
    assign dur_end = (dur_q == '0) ? '0 : dur_q - 1'b1;  // duration 0 plays as 1 tick

    // NOTE: every signal assigned here gets a default first so no latch is inferred.
    always_comb begin
        state_d     = state_q;
        note_addr_d = note_addr_q;
        hp_d        = hp_q;
        dur_d       = dur_q;
        last_d      = last_q;
        tick_d      = tick_q;
        beat_d      = beat_q;
        gap_d       = gap_q;
        done_d      = 1'b0;

        if (stop) begin
            state_d     = S_IDLE;
            note_addr_d = '0;
            tick_d      = '0;
            beat_d      = '0;
            gap_d       = '0;
        end else if (!pause) begin
            unique case (state_q)
                S_IDLE: begin
                    if (play) begin
                        state_d     = S_FETCH;
                        note_addr_d = '0;
                    end
                end
                S_FETCH: state_d = S_LOAD;
                S_LOAD: begin
                    hp_d    = rom_half_period;
                    dur_d   = rom_dur;
                    last_d  = rom_last;
                    tick_d  = '0;
                    beat_d  = '0;
                    state_d = S_PLAY;
                end
                S_PLAY: begin
                    tick_d = tick ? '0 : tick_q + 1'b1;
                    if (tick) begin
                        if (beat_q == dur_end) begin
                            beat_d  = '0;
                            gap_d   = '0;
                            state_d = (GAP_TICKS > 0) ? S_GAP : S_NEXT;
                        end else begin
                            beat_d = beat_q + 1'b1;
                        end
                    end
                end
                S_GAP: begin
                    tick_d = tick ? '0 : tick_q + 1'b1;
                    if (tick) begin
                        if (gap_q == GAP_LAST) begin
                            gap_d   = '0;
                            state_d = S_NEXT;
                        end else begin
                            gap_d = gap_q + 1'b1;
                        end
                    end
                end
                S_NEXT: begin
                    // The final table entry ends the song even without its last flag.
                    if (last_q || note_addr_q == '1) begin
                        note_addr_d = '0;
                        if (loop_en) begin
                            state_d = S_FETCH;
                        end else begin
                            done_d  = 1'b1;
                            state_d = S_IDLE;
                        end
                    end else begin
                        note_addr_d = note_addr_q + 1'b1;
                        state_d     = S_FETCH;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            note_addr_q <= '0;
            hp_q        <= '0;
            dur_q       <= '0;
            last_q      <= 1'b0;
            tick_q      <= '0;
            beat_q      <= '0;
            gap_q       <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            note_addr_q <= note_addr_d;
            hp_q        <= hp_d;
            dur_q       <= dur_d;
            last_q      <= last_d;
            tick_q      <= tick_d;
            beat_q      <= beat_d;
            gap_q       <= gap_d;
            done_q      <= done_d;
        end
    end

    // Tone phase restarts at LOAD and whenever the next cycle is not PLAY,
    // so gaps, stop and note ends are silent from the following cycle.
    assign restart = (state_q == S_LOAD) || (state_d != S_PLAY);

    tone_gen #(
        .HP_W(HP_W)
    ) u_tone_gen (
        .clk        (clk),
        .rst        (rst),
        .restart    (restart),
        .freeze     (pause),
        .half_period(hp_q),
        .sound      (sound)
    );

    assign note_addr = note_addr_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;

endmodule

// File: tb/tb_melody_player.sv
// Directed bench for melody_player: one gapless instance and one with a
// one-tick gap and a four-entry table, both at 10 clocks per tick.
module tb_melody_player;

    localparam int CLK_HZ  = 1000;
    localparam int TICK_HZ = 100;
    localparam int HP_W    = 8;
    localparam int DUR_W   = 4;
    localparam int N       = 200;

    typedef logic bit_arr_t [N];

    logic clk = 1'b0;
    logic rst = 1'b1, play = 1'b0, play_g = 1'b0, stop = 1'b0, pause = 1'b0, loop_en = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Gapless instance with a 64-entry table.
    logic [5:0]       addr;
    logic [HP_W-1:0]  rhp;
    logic [DUR_W-1:0] rdur;
    logic             rlast, sound, busy, done;
    logic [HP_W-1:0]  t_hp   [64];
    logic [DUR_W-1:0] t_dur  [64];
    logic             t_last [64];

    always @(posedge clk) begin
        rhp   <= t_hp[addr];
        rdur  <= t_dur[addr];
        rlast <= t_last[addr];
    end

    melody_player #(
        .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .ADDR_W(6), .HP_W(HP_W), .DUR_W(DUR_W), .GAP_TICKS(0)
    ) dut (
        .clk(clk), .rst(rst), .play(play), .stop(stop), .pause(pause), .loop_en(loop_en),
        .note_addr(addr), .rom_half_period(rhp), .rom_dur(rdur), .rom_last(rlast),
        .sound(sound), .busy(busy), .done(done)
    );

    // One-tick-gap instance with a 4-entry table.
    logic [1:0]       g_addr;
    logic [HP_W-1:0]  g_rhp;
    logic [DUR_W-1:0] g_rdur;
    logic             g_rlast, g_sound, g_busy, g_done;
    logic [HP_W-1:0]  g_hp   [4];
    logic [DUR_W-1:0] g_dur  [4];
    logic             g_last [4];

    always @(posedge clk) begin
        g_rhp   <= g_hp[g_addr];
        g_rdur  <= g_dur[g_addr];
        g_rlast <= g_last[g_addr];
    end

    melody_player #(
        .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .ADDR_W(2), .HP_W(HP_W), .DUR_W(DUR_W), .GAP_TICKS(1)
    ) dut_g (
        .clk(clk), .rst(rst), .play(play_g), .stop(stop), .pause(pause), .loop_en(loop_en),
        .note_addr(g_addr), .rom_half_period(g_rhp), .rom_dur(g_rdur), .rom_last(g_rlast),
        .sound(g_sound), .busy(g_busy), .done(g_done)
    );

    bit_arr_t   c_snd, c_bsy, c_dn, gc_snd, gc_dn;
    logic [5:0] c_adr  [N];
    logic [1:0] gc_adr [N];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic load(input int idx, input int hp, input int dur, input logic last);
        t_hp[idx] = HP_W'(hp); t_dur[idx] = DUR_W'(dur); t_last[idx] = last;
    endtask

    task automatic load_g(input int idx, input int hp, input int dur, input logic last);
        g_hp[idx] = HP_W'(hp); g_dur[idx] = DUR_W'(dur); g_last[idx] = last;
    endtask

    // Sample index i is the i-th cycle after the edge that accepted play.
    task automatic capture(input int n, input int pause_at, input int pause_len, input int stop_at);
        for (int i = 0; i < n; i++) begin
            c_snd[i] = sound;   c_bsy[i] = busy;  c_dn[i] = done;  c_adr[i] = addr;
            gc_snd[i] = g_sound; gc_dn[i] = g_done; gc_adr[i] = g_addr;
            if (i == pause_at) pause = 1'b1;
            if (i == pause_at + pause_len) pause = 1'b0;
            stop = (i == stop_at);
            step();
        end
        stop = 1'b0;
    endtask

    task automatic start(input logic which_g);
        if (which_g) play_g = 1'b1; else play = 1'b1;
        step();
        play = 1'b0; play_g = 1'b0;
    endtask

    function automatic int count_hi(input bit_arr_t a, input int lo, input int hi);
        int n = 0;
        for (int i = lo; i <= hi; i++) if (a[i] === 1'b1) n++;
        return n;
    endfunction

    function automatic int first_hi(input bit_arr_t a, input int from);
        for (int i = from; i < N; i++) if (a[i] === 1'b1) return i;
        return -1;
    endfunction

    function automatic int next_rise(input bit_arr_t a, input int from);
        for (int i = from + 1; i < N; i++) if (a[i] === 1'b1 && a[i-1] === 1'b0) return i;
        return -1;
    endfunction

    initial begin
        for (int i = 0; i < 64; i++) load(i, 0, 0, 1'b0);
        for (int i = 0; i < 4; i++) load_g(i, 0, 0, 1'b0);

        repeat (2) step();
        check("rst_addr", addr, 0);
        check("rst_sound", sound, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rst = 1'b0;
        step();

        // Single note hp=5 dur=2: PLAY at 2..21, NEXT 22, done 23.
        load(0, 5, 2, 1'b1);
        start(1'b0);
        capture(30, -1, 0, -1);
        check("t1_busy_cycles", count_hi(c_bsy, 0, 29), 23);
        check("t1_done_count", count_hi(c_dn, 0, 29), 1);
        check("t1_done_idx", first_hi(c_dn, 0), 23);
        check("t1_first_rise", first_hi(c_snd, 0), 7);
        check("t1_period", next_rise(c_snd, 7), 17);
        check("t1_high_cycles", count_hi(c_snd, 0, 29), 10);

        // Rest (dur 0 = 1 tick) then hp=3 dur=1.
        load(0, 0, 0, 1'b0);
        load(1, 3, 1, 1'b1);
        start(1'b0);
        capture(30, -1, 0, -1);
        check("t2_rest_silent", count_hi(c_snd, 0, 17), 0);
        check("t2_first_rise", first_hi(c_snd, 0), 18);
        check("t2_second_rise", next_rise(c_snd, 18), 24);
        check("t2_addr_at_next", c_adr[12], 0);
        check("t2_addr_at_fetch", c_adr[13], 1);
        check("t2_done_idx", first_hi(c_dn, 0), 26);

        // Gap instance: two notes hp=3 dur=1; gaps at 12..21 and 35..44.
        load_g(0, 3, 1, 1'b0);
        load_g(1, 3, 1, 1'b1);
        start(1'b1);
        capture(50, -1, 0, -1);
        check("t3_gap1_silent", count_hi(gc_snd, 12, 21), 0);
        check("t3_gap2_silent", count_hi(gc_snd, 35, 44), 0);
        check("t3_note1_high", count_hi(gc_snd, 2, 11), 4);
        check("t3_note2_high", count_hi(gc_snd, 25, 34), 4);
        check("t3_done_idx", first_hi(gc_dn, 0), 46);

        // Implicit last: four rests without a last flag, 23 cycles per note.
        for (int i = 0; i < 4; i++) load_g(i, 0, 1, 1'b0);
        start(1'b1);
        capture(100, -1, 0, -1);
        check("t4_addr_top", gc_adr[69], 3);
        check("t4_done_idx", first_hi(gc_dn, 0), 92);
        check("t4_done_count", count_hi(gc_dn, 0, 99), 1);

        // Looping three-note song, 13 cycles per note, stop during note 1.
        load(0, 2, 1, 1'b0);
        load(1, 2, 1, 1'b0);
        load(2, 2, 1, 1'b1);
        loop_en = 1'b1;
        start(1'b0);
        capture(60, -1, 0, 56);
        loop_en = 1'b0;
        for (int k = 0; k < 5; k++) check($sformatf("t5_addr_seq%0d", k), c_adr[13*k], k % 3);
        check("t5_addr_hold", c_adr[12], 0);
        check("t5_sound_before_stop", c_snd[56], 1);
        check("t5_stop_busy", c_bsy[57], 0);
        check("t5_stop_sound", c_snd[57], 0);
        check("t5_stop_addr", c_adr[57], 0);
        check("t5_no_done", count_hi(c_dn, 0, 59), 0);

        // Pause for 37 edges starting at the end of cycle 6.
        load(0, 3, 2, 1'b1);
        start(1'b0);
        capture(65, 6, 37, -1);
        check("t6_sound_pre", c_snd[6], 1);
        check("t6_pause_silent", count_hi(c_snd, 7, 43), 0);
        check("t6_resume_phase", c_snd[44], 1);
        check("t6_resume_toggle", c_snd[45], 0);
        check("t6_done_idx", first_hi(c_dn, 0), 60);
        check("t6_busy_cycles", count_hi(c_bsy, 0, 64), 60);

        // play and stop together in IDLE.
        play = 1'b1; stop = 1'b1;
        step();
        play = 1'b0; stop = 1'b0;
        check("t7_busy0", busy, 0);
        step();
        check("t7_busy1", busy, 0);

        // Reset mid-PLAY of the second note.
        load(0, 2, 1, 1'b0);
        load(1, 2, 3, 1'b1);
        start(1'b0);
        capture(17, -1, 0, -1);
        check("t8_pre_addr", addr, 1);
        check("t8_pre_sound", sound, 1);
        rst = 1'b1;
        step();
        check("t8_rst_addr", addr, 0);
        check("t8_rst_sound", sound, 0);
        check("t8_rst_busy", busy, 0);
        check("t8_rst_done", done, 0);
        rst = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/melody_player.md
# melody_player

Parametrised tune sequencer driving a single-bit square-wave audio output. Walks a note table held in an external synchronous ROM (half-period, duration, last-flag per entry), times each note in tempo ticks derived from the system clock, and inserts an optional articulation gap between notes. Supports play/stop/pause and looping. Sits between the game-state logic (which issues play/stop) and the audio pin; replaces the fixed single-song player.

## Interface
- `CLK_HZ`, 100_000_000, system clock frequency.
- `TICK_HZ`, 32, tempo ticks per second; one tick is the shortest note unit.
- `ADDR_W`, 6, note-table address width; table depth is 2^ADDR_W.
- `HP_W`, 22, half-period field width in clk cycles; 0 encodes a rest.
- `DUR_W`, 4, duration field width in ticks.
- `GAP_TICKS`, 0, silent ticks inserted after every note; 0 disables the gap.
- `clk`  in  1  system clock, all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `play`  in  1  one-cycle start pulse; ignored while busy.
- `stop`  in  1  one-cycle abort pulse; wins over `play`.
- `pause`  in  1  level; freezes the sequencer and forces silence.
- `loop_en`  in  1  sampled at the end of the last note.
- `note_addr`  out  ADDR_W  registered ROM address.
- `rom_half_period`  in  HP_W  ROM data, valid one cycle after `note_addr`.
- `rom_dur`  in  DUR_W  ROM data, note length in ticks.
- `rom_last`  in  1  ROM data, marks the final note.
- `sound`  out  1  square-wave audio.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when a non-looping song ends.

## Operation
- Reset values: state IDLE, `note_addr`=0, `sound`=0, `busy`=0, `done`=0, and all counters 0.
- States and transitions:
  - IDLE: on `play` (and not `stop`), go to FETCH with `note_addr`=0.
  - FETCH: one cycle while the ROM reads.
  - LOAD: latch half-period, duration and last; clear the tick and tone counters; go to PLAY.
  - PLAY: run for `dur` ticks.
    - If `GAP_TICKS`>0, go to GAP.
    - Otherwise go to NEXT.
  - GAP: `sound`=0 for `GAP_TICKS` ticks, then go to NEXT.
  - NEXT: one cycle.
    - If last, or `note_addr`==2^ADDR_W-1 (implicit last, no wrap past the table):
      - with `loop_en`=1, set `note_addr`=0 and go to FETCH;
      - otherwise pulse `done` and go to IDLE.
    - Else increment `note_addr` and go to FETCH.
- Duration 0 is treated as 1 tick.
- Tick generator:
  - Counts 0..CLK_HZ/TICK_HZ-1 and pulses on the terminal count.
  - Restarts from 0 in LOAD and on entry to GAP, so every note is exactly dur×CLK_HZ/TICK_HZ cycles.
- Tone:
  - Counter restarts at LOAD with `sound`=0 (phase-aligned note start).
  - `sound` toggles when the counter reaches half_period-1, then the counter returns to 0.
  - half_period 0 holds `sound`=0 (rest).
  - half_period 1 toggles every cycle.
- `stop` in any state: next cycle is IDLE, `sound`=0, `note_addr`=0, and no `done` pulse.
- `pause`=1:
  - The tick counter, tone counter, duration counter and state all hold, and `sound` is forced to 0.
  - On release, playback resumes exactly where it was held.
  - `stop` overrides `pause`.
- `play` while busy is ignored. `play` and `stop` in the same cycle means stop.
- `rst` mid-song returns every register to its reset value on the next edge.

## Timing
- `play` sampled at edge N: FETCH at N+1, LOAD at N+2, first PLAY cycle at N+3. The first `sound` toggle occurs half_period cycles after LOAD.
- Note-to-note overhead is 3 cycles (NEXT, FETCH, LOAD), included in neither duration nor gap.
- `done` is asserted during the cycle after NEXT, coincident with `busy` falling.
- `note_addr` changes only on the edge into FETCH.
- `sound` is a registered output with no combinational path from inputs.

## Structure
- Shared package `audio_pkg` holds:
  - the note half-period constants (B4, C5, DS5, E5, F5, FS5, G5, GS5, A5, B5, C6, E6, G6), each computed as CLK_HZ/(2·f);
  - the REST=0 constant;
  - the state enum.
- One sub-module: `tone_gen` (clk, rst, restart, freeze, half_period → sound).
- The tick divider and FSM live in `melody_player`.

## Test plan
- CLK_HZ=1000, TICK_HZ=100, single note {hp=5, dur=2, last=1}, loop_en=0, then pulse `play`:
  - `sound` period is 10 cycles across 20 cycles of PLAY;
  - `done` pulses once, and `busy` is high for exactly 23 cycles.
- Table {hp=0, dur=1}, {hp=3, dur=1, last=1}:
  - `sound`=0 for the 10-cycle rest;
  - then `sound` toggles every 3 cycles;
  - `note_addr` goes 0 then 1.
- GAP_TICKS=1, two notes of dur=1: a 10-cycle silent window follows each note, and `done` fires after the second gap.
- loop_en=1, three-entry song: `note_addr` sequence 0,1,2,0,1 with no `done`. Pulse `stop` mid-note 1: next cycle IDLE, `sound`=0, `note_addr`=0.
- Assert `pause` for 37 cycles mid-note: note length extends by exactly 37 cycles, `sound`=0 throughout the pause, and the toggle phase is preserved after release.
- `play` and `stop` asserted together in IDLE: the block stays IDLE. `rst` asserted mid-PLAY: all outputs return to reset values on the next edge.
